// File: rtl/eth_pkg.sv
// -----------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the Ethernet test-frame generator and its companion
// RX checker: frame geometry, payload mode codes, generator FSM states and the
// PRBS8 next-state function.
// Ports: none (package).
// -----------------------------------------------------------------------------
package eth_pkg;

  localparam int ETH_HDR_LEN = 14;
  localparam int ETH_MIN_LEN = 60;
  localparam int ETH_MAX_LEN = 1514;

  // Payload modes; code 3 behaves like MODE_INC.
  localparam logic [1:0] MODE_INC   = 2'd0;
  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_PRBS  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP
  } gen_state_e;

  // x^8+x^6+x^5+x^4+1 Fibonacci LFSR, shifting towards the MSB.
  function automatic logic [7:0] prbs8_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/eth_prbs8.sv
// -----------------------------------------------------------------------------
// eth_prbs8
// PRBS8 payload generator (x^8+x^6+x^5+x^4+1). Shared with the RX checker.
// Ports:
//   clk_mac  in  MAC clock
//   rst      in  synchronous active-high reset
//   load     in  load seed (an all-zero seed is replaced by 8'h01); wins over adv
//   seed     in  8-bit seed
//   adv      in  advance one step
//   q        out current PRBS byte
// -----------------------------------------------------------------------------
module eth_prbs8
  import eth_pkg::*;
(
  input  logic       clk_mac,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       adv,
  output logic [7:0] q
);

  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      // The all-zero state would lock the LFSR up.
      q_d = (seed == 8'h00) ? 8'h01 : seed;
    end else if (adv) begin
      q_d = prbs8_step(q_q);
    end
  end

  always_ff @(posedge clk_mac) begin
    if (rst) begin
      q_q <= 8'h01;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/eth_pkt_gen.sv
// -----------------------------------------------------------------------------
// eth_pkt_gen
// Ethernet test-frame generator feeding the MAC TX AXI-Stream. Sends dst MAC,
// src MAC, ethertype and a payload (incrementing / constant / PRBS8) of
// run-time length, in bursts or continuously, with a programmable gap.
// Ports:
//   clk_mac, rst             clock, synchronous active-high reset
//   start, stop              begin a burst / finish current frame then idle
//   dst_mac, src_mac, ethertype, pkt_len, mode, pattern, pkt_count, gap_cycles
//                            configuration, latched on start
//   tx_axis_mac_t*           byte stream towards the MAC
//   busy, done, pkts_sent    status
// -----------------------------------------------------------------------------
module eth_pkt_gen
  import eth_pkg::*;
#(
  parameter int LEN_W   = 11,
  parameter int MIN_LEN = ETH_MIN_LEN,
  parameter int MAX_LEN = ETH_MAX_LEN,
  parameter int CNT_W   = 16,
  parameter int GAP_W   = 16
) (
  input  logic             clk_mac,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [47:0]      dst_mac,
  input  logic [47:0]      src_mac,
  input  logic [15:0]      ethertype,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic [1:0]       mode,
  input  logic [7:0]       pattern,
  input  logic [CNT_W-1:0] pkt_count,
  input  logic [GAP_W-1:0] gap_cycles,
  output logic [7:0]       tx_axis_mac_tdata,
  output logic             tx_axis_mac_tvalid,
  output logic             tx_axis_mac_tlast,
  input  logic             tx_axis_mac_tready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pkts_sent
);

  localparam logic [LEN_W-1:0] HDR_L = LEN_W'(ETH_HDR_LEN);
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

  gen_state_e       state_q, state_d;
  logic [47:0]      dst_q, dst_d;
  logic [47:0]      src_q, src_d;
  logic [15:0]      type_q, type_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       pattern_q, pattern_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic             stop_flag_q, stop_flag_d;
  logic [CNT_W-1:0] pkts_sent_q, pkts_sent_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic             done_q, done_d;

  logic             prbs_load, prbs_adv;
  logic [7:0]       prbs_q;
  logic [LEN_W-1:0] nidx;
  logic [7:0]       next_byte, payload_byte;
  logic             frame_end;
  logic [CNT_W-1:0] sent_inc, sent_eval;

  eth_prbs8 u_prbs (
    .clk_mac (clk_mac),
    .rst     (rst),
    .load    (prbs_load),
    .seed    (pattern_q),
    .adv     (prbs_adv),
    .q       (prbs_q)
  );

  // Byte that follows the one currently on the bus. The registered outputs
  // need the value one byte ahead, so for PRBS the LFSR's next state is used
  // except for the first payload byte, which is the freshly loaded seed.
  always_comb begin
    nidx = idx_q + ONE_L;
    unique case (mode_q)
      MODE_CONST: payload_byte = pattern_q;
      MODE_PRBS:  payload_byte = (nidx == HDR_L) ? prbs_q : prbs8_step(prbs_q);
      default:    payload_byte = nidx[7:0];
    endcase
    next_byte = payload_byte;
    if (nidx < HDR_L) begin
      unique case (nidx[3:0])
        4'd0:    next_byte = dst_q[47:40];
        4'd1:    next_byte = dst_q[39:32];
        4'd2:    next_byte = dst_q[31:24];
        4'd3:    next_byte = dst_q[23:16];
        4'd4:    next_byte = dst_q[15:8];
        4'd5:    next_byte = dst_q[7:0];
        4'd6:    next_byte = src_q[47:40];
        4'd7:    next_byte = src_q[39:32];
        4'd8:    next_byte = src_q[31:24];
        4'd9:    next_byte = src_q[23:16];
        4'd10:   next_byte = src_q[15:8];
        4'd11:   next_byte = src_q[7:0];
        4'd12:   next_byte = type_q[15:8];
        4'd13:   next_byte = type_q[7:0];
        default: next_byte = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    dst_d       = dst_q;
    src_d       = src_q;
    type_d      = type_q;
    len_d       = len_q;
    mode_d      = mode_q;
    pattern_d   = pattern_q;
    count_d     = count_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    idx_d       = idx_q;
    stop_flag_d = stop_flag_q;
    pkts_sent_d = pkts_sent_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    done_d      = 1'b0;
    prbs_load   = 1'b0;
    prbs_adv    = 1'b0;
    frame_end   = 1'b0;
    sent_eval   = pkts_sent_q;
    sent_inc    = (&pkts_sent_q) ? pkts_sent_q : pkts_sent_q + CNT_W'(1);

    if (state_q != ST_IDLE) begin
      stop_flag_d = stop_flag_q | stop;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          dst_d       = dst_mac;
          src_d       = src_mac;
          type_d      = ethertype;
          len_d       = pkt_len;
          mode_d      = mode;
          pattern_d   = pattern;
          count_d     = pkt_count;
          gap_d       = gap_cycles;
          pkts_sent_d = '0;
          stop_flag_d = stop;  // start+stop together: one frame then idle
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (len_q < MIN_L) begin
          len_d = MIN_L;
        end else if (len_q > MAX_L) begin
          len_d = MAX_L;
        end
        idx_d     = '0;
        prbs_load = 1'b1;
        tvalid_d  = 1'b1;
        tlast_d   = 1'b0;
        tdata_d   = dst_q[47:40];
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (tvalid_q && tx_axis_mac_tready) begin
          prbs_adv = (idx_q >= HDR_L);
          if (tlast_q) begin
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            pkts_sent_d = sent_inc;
            if (gap_q != '0) begin
              gap_cnt_d = gap_q - GAP_W'(1);
              state_d   = ST_GAP;
            end else begin
              frame_end = 1'b1;
              sent_eval = sent_inc;
            end
          end else begin
            idx_d   = nidx;
            tdata_d = next_byte;
            tlast_d = (nidx == len_q - ONE_L);
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          frame_end = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // End of a frame's gap (or of the frame itself when the gap is zero):
    // either finish the burst or put byte 0 of the next frame straight on the
    // bus so the idle time between frames is exactly gap_cycles.
    if (frame_end) begin
      if (stop_flag_q || stop || (count_q != '0 && sent_eval == count_q)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d   = ST_SEND;
        idx_d     = '0;
        prbs_load = 1'b1;
        tvalid_d  = 1'b1;
        tlast_d   = 1'b0;
        tdata_d   = dst_q[47:40];
      end
    end
  end

  always_ff @(posedge clk_mac) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dst_q       <= '0;
      src_q       <= '0;
      type_q      <= '0;
      len_q       <= '0;
      mode_q      <= '0;
      pattern_q   <= '0;
      count_q     <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      idx_q       <= '0;
      stop_flag_q <= 1'b0;
      pkts_sent_q <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      type_q      <= type_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      pattern_q   <= pattern_d;
      count_q     <= count_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      idx_q       <= idx_d;
      stop_flag_q <= stop_flag_d;
      pkts_sent_q <= pkts_sent_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      done_q      <= done_d;
    end
  end

  assign tx_axis_mac_tdata  = tdata_q;
  assign tx_axis_mac_tvalid = tvalid_q;
  assign tx_axis_mac_tlast  = tlast_q;
  assign busy               = (state_q != ST_IDLE);
  assign done               = done_q;
  assign pkts_sent          = pkts_sent_q;

endmodule

// File: tb/tb_eth_pkt_gen.sv
// -----------------------------------------------------------------------------
// tb_eth_pkt_gen
// Scoreboard bench for eth_pkt_gen: each start pushes the expected frames,
// computed from the frame format rules, into a queue; a negedge monitor pops
// and compares every accepted byte, checks hold-while-stalled and the gap
// length between frames.
// -----------------------------------------------------------------------------
module tb_eth_pkt_gen;

  localparam int LEN_W = 11;
  localparam int CNT_W = 16;
  localparam int GAP_W = 16;

  logic             clk_mac = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [47:0]      dst_mac = '0;
  logic [47:0]      src_mac = '0;
  logic [15:0]      ethertype = '0;
  logic [LEN_W-1:0] pkt_len = '0;
  logic [1:0]       mode = '0;
  logic [7:0]       pattern = '0;
  logic [CNT_W-1:0] pkt_count = '0;
  logic [GAP_W-1:0] gap_cycles = '0;
  logic [7:0]       tx_axis_mac_tdata;
  logic             tx_axis_mac_tvalid;
  logic             tx_axis_mac_tlast;
  logic             tx_axis_mac_tready = 1'b1;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pkts_sent;

  eth_pkt_gen dut (
    .clk_mac            (clk_mac),
    .rst                (rst),
    .start              (start),
    .stop               (stop),
    .dst_mac            (dst_mac),
    .src_mac            (src_mac),
    .ethertype          (ethertype),
    .pkt_len            (pkt_len),
    .mode               (mode),
    .pattern            (pattern),
    .pkt_count          (pkt_count),
    .gap_cycles         (gap_cycles),
    .tx_axis_mac_tdata  (tx_axis_mac_tdata),
    .tx_axis_mac_tvalid (tx_axis_mac_tvalid),
    .tx_axis_mac_tlast  (tx_axis_mac_tlast),
    .tx_axis_mac_tready (tx_axis_mac_tready),
    .busy               (busy),
    .done               (done),
    .pkts_sent          (pkts_sent)
  );

  always #10 clk_mac = ~clk_mac;

  int cyc = 0;
  initial forever begin
    @(posedge clk_mac);
    cyc = cyc + 1;
  end

  int total = 0;
  int bad = 0;

  logic [8:0] exp_q[$];
  int exp_gap = 0;
  bit lat_check = 0;
  int start_cyc = 0;
  int last_tlast_cyc = 0;
  int frames_done = 0;
  int byte_in_frame = 0;
  bit in_frame = 0;
  bit rand_ready = 0;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  // PRBS8 x^8+x^6+x^5+x^4+1: feedback is the parity of the tapped bits.
  function automatic logic [7:0] lfsr_next(logic [7:0] s);
    return {s[6:0], ^(s & 8'b1011_1000)};
  endfunction

  // Reference frame: header fields MSB first, then payload per mode.
  function automatic void push_frame(logic [47:0] d, logic [47:0] s, logic [15:0] t,
                                     int len, int m, logic [7:0] pat);
    int n;
    logic [7:0] lf;
    logic [7:0] b;
    n  = (len < 60) ? 60 : ((len > 1514) ? 1514 : len);
    lf = (pat == 8'h00) ? 8'h01 : pat;
    for (int i = 0; i < n; i++) begin
      if (i < 6)       b = 8'(d >> (8 * (5 - i)));
      else if (i < 12) b = 8'(s >> (8 * (11 - i)));
      else if (i < 14) b = 8'(t >> (8 * (13 - i)));
      else if (m == 1) b = pat;
      else if (m == 2) begin
        b  = lf;
        lf = lfsr_next(lf);
      end else         b = 8'(i);
      exp_q.push_back({(i == n - 1), b});
    end
  endfunction

  // tready: held high or toggled randomly, changed just after each edge.
  initial forever begin
    @(posedge clk_mac);
    #1;
    tx_axis_mac_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor
  initial begin : monitor
    bit hold;
    logic [7:0] hd;
    logic hl;
    bit counting;
    int lowcnt;
    logic [8:0] e;
    hold = 0;
    hd = '0;
    hl = 0;
    counting = 0;
    lowcnt = 0;
    forever begin
      @(negedge clk_mac);
      if (rst) begin
        hold = 0;
        in_frame = 0;
        counting = 0;
      end else begin
        if (hold) begin
          chk("hold_while_stalled", 64'({tx_axis_mac_tvalid, tx_axis_mac_tlast, tx_axis_mac_tdata}),
              64'({1'b1, hl, hd}));
        end
        hold = tx_axis_mac_tvalid && !tx_axis_mac_tready;
        hd = tx_axis_mac_tdata;
        hl = tx_axis_mac_tlast;
        if (tx_axis_mac_tvalid && !in_frame) begin
          in_frame = 1;
          byte_in_frame = 0;
          if (counting) begin
            chk("gap_cycles", 64'(lowcnt), 64'(exp_gap));
            counting = 0;
          end
          if (lat_check) begin
            chk("start_latency", 64'(cyc), 64'(start_cyc + 2));
            lat_check = 0;
          end
        end
        if (!tx_axis_mac_tvalid && counting) lowcnt = lowcnt + 1;
        if (done) counting = 0;
        if (tx_axis_mac_tvalid && tx_axis_mac_tready) begin
          if (exp_q.size() == 0) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL unexpected_byte: got=%0h expected=none (cycle %0d)",
                     {tx_axis_mac_tlast, tx_axis_mac_tdata}, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("byte_tlast_tdata", 64'({tx_axis_mac_tlast, tx_axis_mac_tdata}), 64'(e));
          end
          byte_in_frame = byte_in_frame + 1;
          if (tx_axis_mac_tlast) begin
            in_frame = 0;
            counting = 1;
            lowcnt = 0;
            frames_done = frames_done + 1;
            last_tlast_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic do_start(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                          input int len, input int m, input logic [7:0] pat,
                          input int cnt, input int gap, input bit with_stop, input int nframes);
    @(posedge clk_mac);
    #1;
    dst_mac    = d;
    src_mac    = s;
    ethertype  = t;
    pkt_len    = LEN_W'(len);
    mode       = 2'(m);
    pattern    = pat;
    pkt_count  = CNT_W'(cnt);
    gap_cycles = GAP_W'(gap);
    start      = 1'b1;
    stop       = with_stop;
    start_cyc  = cyc;
    lat_check  = 1;
    exp_gap    = gap;
    for (int f = 0; f < nframes; f++) push_frame(d, s, t, len, m, pat);
    @(posedge clk_mac);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    // Config must have been latched; scramble the inputs.
    dst_mac   = 48'({$urandom(), $urandom()});
    src_mac   = 48'({$urandom(), $urandom()});
    ethertype = 16'($urandom());
    pkt_len   = LEN_W'($urandom());
    mode      = 2'($urandom());
    pattern   = 8'($urandom());
  endtask

  task automatic wait_done(input int exp_sent, input int gap);
    bit seen;
    seen = 0;
    for (int k = 0; k < 20000 && !seen; k++) begin
      @(negedge clk_mac);
      if (done) seen = 1;
    end
    chk("done_seen", 64'(seen), 64'(1));
    if (seen) begin
      chk("done_timing", 64'(cyc), 64'(last_tlast_cyc + gap + 1));
      chk("busy_at_done", 64'(busy), 64'(0));
      chk("pkts_sent", 64'(pkts_sent), 64'(exp_sent));
      chk("leftover_bytes", 64'(exp_q.size()), 64'(0));
      @(negedge clk_mac);
      chk("done_pulse_width", 64'(done), 64'(0));
      chk("pkts_sent_hold", 64'(pkts_sent), 64'(exp_sent));
    end
    repeat (3) @(posedge clk_mac);
  endtask

  task automatic wait_mid_frame(input int frame_target, input int min_byte);
    bit ok;
    ok = 0;
    for (int k = 0; k < 20000 && !ok; k++) begin
      @(negedge clk_mac);
      if (frames_done == frame_target && in_frame && byte_in_frame >= min_byte) ok = 1;
    end
    chk("reach_mid_frame", 64'(ok), 64'(1));
  endtask

  initial begin : watchdog
    #(20 * 200000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int f0;
    repeat (3) @(posedge clk_mac);
    @(negedge clk_mac);
    chk("reset_tvalid", 64'(tx_axis_mac_tvalid), 64'(0));
    chk("reset_tlast", 64'(tx_axis_mac_tlast), 64'(0));
    chk("reset_tdata", 64'(tx_axis_mac_tdata), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_pkts_sent", 64'(pkts_sent), 64'(0));
    @(posedge clk_mac);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk_mac);

    // 1: basic 64-byte incrementing frame, tready high
    rand_ready = 0;
    do_start(48'hFFFF_FFFF_FFFF, 48'h0, 16'hEBEB, 64, 0, 8'h00, 1, 0, 0, 1);
    wait_done(1, 0);

    // 2: same frame, random backpressure
    rand_ready = 1;
    do_start(48'hFFFF_FFFF_FFFF, 48'h0, 16'hEBEB, 64, 0, 8'h00, 1, 0, 0, 1);
    wait_done(1, 0);

    // 3: length clamping, constant payload
    do_start(48'h0011_2233_4455, 48'h6677_8899_AABB, 16'h0800, 20, 1, 8'hA5, 1, 2, 0, 1);
    wait_done(1, 2);
    rand_ready = 0;
    do_start(48'hDEAD_BEEF_0001, 48'h0202_0303_0404, 16'h88B5, 2000, 1, 8'hA5, 1, 0, 0, 1);
    wait_done(1, 0);

    // 4: PRBS with zero seed, 3 frames, gap 12
    rand_ready = 1;
    do_start(48'h1234_5678_9ABC, 48'hCAFE_F00D_0042, 16'h9000, 80, 2, 8'h00, 3, 12, 0, 3);
    wait_done(3, 12);

    // 5: continuous, stop mid frame 2, start while busy ignored
    rand_ready = 0;
    f0 = frames_done;
    do_start(48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6, 16'h1234, 60, 0, 8'h00, 0, 3, 0, 2);
    wait_mid_frame(f0 + 1, 20);
    @(posedge clk_mac);
    #1;
    stop = 1'b1;
    start = 1'b1;
    pkt_len = LEN_W'(100);
    pkt_count = CNT_W'(7);
    @(posedge clk_mac);
    #1;
    stop = 1'b0;
    start = 1'b0;
    wait_done(2, 3);

    // 6: reset mid-frame, then a clean frame
    f0 = frames_done;
    do_start(48'h0A0B_0C0D_0E0F, 48'h1011_1213_1415, 16'h86DD, 100, 0, 8'h00, 2, 2, 0, 2);
    wait_mid_frame(f0 + 1, 30);
    @(posedge clk_mac);
    #1;
    rst = 1'b1;
    @(posedge clk_mac);
    @(negedge clk_mac);
    chk("rst_mid_tvalid", 64'(tx_axis_mac_tvalid), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_pkts_sent", 64'(pkts_sent), 64'(0));
    exp_q.delete();
    @(posedge clk_mac);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk_mac);
    do_start(48'h0A0B_0C0D_0E0F, 48'h1011_1213_1415, 16'h86DD, 70, 2, 8'h3C, 1, 0, 0, 1);
    wait_done(1, 0);

    // 7: start and stop in the same cycle -> exactly one frame
    do_start(48'h5555_AAAA_5555, 48'h0F0F_F0F0_0F0F, 16'h0806, 61, 0, 8'h00, 5, 4, 1, 1);
    wait_done(1, 4);

    // Random configurations
    rand_ready = 1;
    for (int r = 0; r < 5; r++) begin
      int len, m, cnt, gap;
      logic [7:0] pat;
      len = $urandom_range(10, 260);
      m   = $urandom_range(0, 3);
      cnt = $urandom_range(1, 3);
      gap = $urandom_range(0, 6);
      pat = 8'($urandom());
      do_start(48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 16'($urandom()),
               len, m, pat, cnt, gap, 0, cnt);
      wait_done(cnt, gap);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
